shifter_arbiter: RTL

- Shares one combinational Shifter instance (32-bit; op 00 logical right, 01 arithmetic right, 10 logical left) between two requesters, A and B.
- A is the execute stage; B is an auxiliary unit such as the mult/div sequencer.
- Round-robin arbitration, operand capture, a registered result and per-requester completion pulses.
- Sits in the execute path beside the ALU; the Shifter itself is instantiated inside this block.

---
 rtl/shifter_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/shifter_arbiter.sv
// Round-robin arbiter that shares one combinational shifter between the execute
// stage (A) and an auxiliary unit (B), with operand capture and a registered result.

module Shifter #(
    parameter int WIDTH = 32,
    parameter int AMT_W = 5
) (
    input  logic [1:0]       op,
    input  logic [AMT_W-1:0] amt,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] y
);
    always_comb begin
        y = '0;
        case (op)
            2'b00:   y = data >> amt;
            2'b01:   y = WIDTH'($signed(data) >>> amt);
            2'b10:   y = data << amt;
            default: y = '0;
        endcase
    end
endmodule

module shifter_arbiter #(
    parameter int WIDTH      = 32,
    parameter int AMT_W      = 5,
    parameter int FIRST_PRIO = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             a_req,
    input  logic [1:0]       a_op,
    input  logic [AMT_W-1:0] a_amt,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_gnt,
    output logic             a_done,
    input  logic             b_req,
    input  logic [1:0]       b_op,
    input  logic [AMT_W-1:0] b_amt,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_gnt,
    output logic             b_done,
    output logic [WIDTH-1:0] result,
    output logic             err,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t           state;
    logic [1:0]       op_q;
    logic [AMT_W-1:0] amt_q;
    logic [WIDTH-1:0] data_q;
    logic             owner_b;
    logic             last_b;
    logic             pick_b;
    logic [WIDTH-1:0] shift_y;

    // On a tie, the requester that was not served last wins.
    assign pick_b = b_req && (!a_req || !last_b);

    Shifter #(.WIDTH(WIDTH), .AMT_W(AMT_W)) u_shifter (
        .op   (op_q),
        .amt  (amt_q),
        .data (data_q),
        .y    (shift_y)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            op_q    <= '0;
            amt_q   <= '0;
            data_q  <= '0;
            owner_b <= 1'b0;
            last_b  <= (FIRST_PRIO == 0);
            result  <= '0;
            err     <= 1'b0;
            busy    <= 1'b0;
            a_gnt   <= 1'b0;
            b_gnt   <= 1'b0;
            a_done  <= 1'b0;
            b_done  <= 1'b0;
        end else begin
            a_gnt  <= 1'b0;
            b_gnt  <= 1'b0;
            a_done <= 1'b0;
            b_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (a_req || b_req) begin
                        op_q    <= pick_b ? b_op : a_op;
                        amt_q   <= pick_b ? b_amt : a_amt;
                        data_q  <= pick_b ? b_data : a_data;
                        owner_b <= pick_b;
                        last_b  <= pick_b;
                        a_gnt   <= !pick_b;
                        b_gnt   <= pick_b;
                        busy    <= 1'b1;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    // The shifter already yields zero for the illegal opcode.
                    result <= shift_y;
                    err    <= (op_q == 2'b11);
                    a_done <= !owner_b;
                    b_done <= owner_b;
                    state  <= DONE;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
